priority_encoder: RTL and testbench

PRIORITY_ENCODER -- requirements
Module: priority_encoder

---
 rtl/priority_encoder.sv | 68 ++++++
 tb/tb_priority_encoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// Registered priority encoder: binary index and valid flag of the winning request bit.
// Define PRIORITY_ENCODER_ONEHOT_EN to add the registered one-hot output Y_oh.
module priority_encoder #(
  parameter int  WIDTH     = 4,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int YW        = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  output logic [YW-1:0]    Y,
  output logic             V
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  , output logic [WIDTH-1:0] Y_oh
`endif
);

  logic [YW-1:0] y_d, y_q;
  logic          v_d, v_q;

  // Later loop iterations overwrite earlier ones, so the scan order picks the winner.
  always_comb begin
    y_d = '0;
    v_d = |D;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (D[i]) y_d = YW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (D[i]) y_d = YW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign Y = y_q;
  assign V = v_q;

`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [WIDTH-1:0] y_oh_d, y_oh_q;

  always_comb begin
    y_oh_d = '0;
    if (v_d) y_oh_d = WIDTH'(1) << y_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_oh_q <= '0;
    end else begin
      y_oh_q <= y_oh_d;
    end
  end

  assign Y_oh = y_oh_q;
`endif

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder: three instances (4-bit MSB-first, 4-bit LSB-first,
// 5-bit MSB-first) checked against an arithmetic reference model.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] d_m4, d_l4;
  logic [4:0] d_m5;
  logic [1:0] y_m4, y_l4;
  logic [2:0] y_m5;
  logic       v_m4, v_l4, v_m5;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
  logic [3:0] oh_m4, oh_l4;
  logic [4:0] oh_m5;
`endif

  int total = 0;
  int bad   = 0;

  priority_encoder #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
    .clk(clk), .rst_n(rst_n), .D(d_m4), .Y(y_m4), .V(v_m4)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    , .Y_oh(oh_m4)
`endif
  );

  priority_encoder #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l4 (
    .clk(clk), .rst_n(rst_n), .D(d_l4), .Y(y_l4), .V(v_l4)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    , .Y_oh(oh_l4)
`endif
  );

  priority_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u_m5 (
    .clk(clk), .rst_n(rst_n), .D(d_m5), .Y(y_m5), .V(v_m5)
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    , .Y_oh(oh_m5)
`endif
  );

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: index of highest set bit via repeated halving.
  function automatic int ref_msb(input longint unsigned d);
    longint unsigned x = d;
    int idx = 0;
    if (x == 0) return 0;
    while (x > 1) begin
      x = x / 2;
      idx++;
    end
    return idx;
  endfunction

  // Reference: index of lowest set bit via counting trailing even divisions.
  function automatic int ref_lsb(input longint unsigned d);
    longint unsigned x = d;
    int idx = 0;
    if (x == 0) return 0;
    while (x % 2 == 0) begin
      x = x / 2;
      idx++;
    end
    return idx;
  endfunction

  function automatic longint unsigned ref_oh(input longint unsigned d, input int idx);
    if (d == 0) return 0;
    return longint'(2) ** idx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    d_m4 = 4'b1111; d_l4 = 4'b1111; d_m5 = 5'b11111;
    rst_n = 1'b0;
    #3;
    total++;
    if (y_m4 !== 2'b00 || v_m4 !== 1'b0 || y_l4 !== 2'b00 || v_l4 !== 1'b0 ||
        y_m5 !== 3'b000 || v_m5 !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial: got m4=%0d/%0b l4=%0d/%0b m5=%0d/%0b need all 0",
               y_m4, v_m4, y_l4, v_l4, y_m5, v_m5);
    end
    tick();
    tick();
    total++;
    if (y_m4 !== 2'b00 || v_m4 !== 1'b0 || y_m5 !== 3'b000 || v_m5 !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got m4=%0d/%0b m5=%0d/%0b need all 0 while rst_n low",
               y_m4, v_m4, y_m5, v_m5);
    end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    total++;
    if (oh_m4 !== 4'b0000 || oh_m5 !== 5'b00000) begin
      bad++;
      $display("FAIL reset_oh: got %b %b need zeros", oh_m4, oh_m5);
    end
`endif
    d_m4 = 4'b0000; d_l4 = 4'b0000; d_m5 = 5'b00000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_msb_sequence();
    logic [3:0] pat [4] = '{4'b1000, 4'b1111, 4'b0111, 4'b0001};
    logic [1:0] exp_y [4] = '{2'b11, 2'b11, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      d_m4 = pat[i];
      tick();
      total++;
      if (y_m4 !== exp_y[i] || v_m4 !== 1'b1) begin
        bad++;
        $display("FAIL msb_seq[%0d]: D=%b got Y=%b V=%b need Y=%b V=1",
                 i, pat[i], y_m4, v_m4, exp_y[i]);
      end
    end
  endtask

  task automatic test_zero();
    d_m4 = 4'b0100;
    tick();
    d_m4 = 4'b0000;
    tick();
    total++;
    if (y_m4 !== 2'b00 || v_m4 !== 1'b0) begin
      bad++;
      $display("FAIL zero_input: got Y=%b V=%b need Y=00 V=0", y_m4, v_m4);
    end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    total++;
    if (oh_m4 !== 4'b0000) begin
      bad++;
      $display("FAIL zero_oh: got %b need 0000", oh_m4);
    end
`endif
  endtask

  task automatic test_lsb_first();
    d_l4 = 4'b0110;
    tick();
    total++;
    if (y_l4 !== 2'b01 || v_l4 !== 1'b1) begin
      bad++;
      $display("FAIL lsb_0110: got Y=%b V=%b need Y=01 V=1", y_l4, v_l4);
    end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    total++;
    if (oh_l4 !== 4'b0010) begin
      bad++;
      $display("FAIL lsb_0110_oh: got %b need 0010", oh_l4);
    end
`endif
    d_l4 = 4'b1000;
    tick();
    total++;
    if (y_l4 !== 2'b11 || v_l4 !== 1'b1) begin
      bad++;
      $display("FAIL lsb_1000: got Y=%b V=%b need Y=11 V=1", y_l4, v_l4);
    end
  endtask

  task automatic test_async_reset();
    d_m4 = 4'b1000;
    tick();
    total++;
    if (y_m4 !== 2'b11 || v_m4 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got Y=%b V=%b need Y=11 V=1", y_m4, v_m4);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (y_m4 !== 2'b00 || v_m4 !== 1'b0) begin
      bad++;
      $display("FAIL async_assert: got Y=%b V=%b need Y=00 V=0 without clock", y_m4, v_m4);
    end
    d_m4 = 4'b0100;
    tick();
    total++;
    if (y_m4 !== 2'b00 || v_m4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_held_edge: got Y=%b V=%b need Y=00 V=0", y_m4, v_m4);
    end
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (y_m4 !== 2'b10 || v_m4 !== 1'b1) begin
      bad++;
      $display("FAIL first_after_release: got Y=%b V=%b need Y=10 V=1", y_m4, v_m4);
    end
  endtask

  task automatic test_width5();
    logic [2:0] exp_y;
    d_m5 = 5'b10000;
    tick();
    total++;
    if (y_m5 !== 3'b100 || v_m5 !== 1'b1) begin
      bad++;
      $display("FAIL w5_10000: got Y=%b V=%b need Y=100 V=1", y_m5, v_m5);
    end
    for (int i = 0; i < 32; i++) begin
      d_m5 = 5'(i);
      tick();
      exp_y = 3'(ref_msb(longint'(i)));
      total++;
      if (y_m5 !== exp_y || v_m5 !== (i != 0) || y_m5 > 3'd4) begin
        bad++;
        $display("FAIL w5_sweep: D=%b got Y=%b V=%b need Y=%b V=%0b",
                 5'(i), y_m5, v_m5, exp_y, (i != 0));
      end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      total++;
      if (oh_m5 !== 5'(ref_oh(longint'(i), ref_msb(longint'(i))))) begin
        bad++;
        $display("FAIL w5_sweep_oh: D=%b got %b", 5'(i), oh_m5);
      end
`endif
    end
  endtask

  task automatic test_back_to_back_random();
    logic [3:0] a, b;
    logic [4:0] c;
    for (int n = 0; n < 300; n++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      c = 5'($urandom_range(0, 31));
      d_m4 = a; d_l4 = b; d_m5 = c;
      tick();
      total++;
      if (y_m4 !== 2'(ref_msb(longint'(a))) || v_m4 !== (a != 0)) begin
        bad++;
        $display("FAIL rand_m4: D=%b got Y=%b V=%b need Y=%0d", a, y_m4, v_m4, ref_msb(longint'(a)));
      end
      total++;
      if (y_l4 !== 2'(ref_lsb(longint'(b))) || v_l4 !== (b != 0)) begin
        bad++;
        $display("FAIL rand_l4: D=%b got Y=%b V=%b need Y=%0d", b, y_l4, v_l4, ref_lsb(longint'(b)));
      end
      total++;
      if (y_m5 !== 3'(ref_msb(longint'(c))) || v_m5 !== (c != 0)) begin
        bad++;
        $display("FAIL rand_m5: D=%b got Y=%b V=%b need Y=%0d", c, y_m5, v_m5, ref_msb(longint'(c)));
      end
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      total++;
      if (oh_m4 !== 4'(ref_oh(longint'(a), ref_msb(longint'(a)))) ||
          oh_l4 !== 4'(ref_oh(longint'(b), ref_lsb(longint'(b))))) begin
        bad++;
        $display("FAIL rand_oh: Da=%b Db=%b got %b %b", a, b, oh_m4, oh_l4);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_msb_sequence();
    test_zero();
    test_lsb_first();
    test_async_reset();
    test_width5();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
